// File: rtl/call_ret_unit_if.sv
// Bundle between the decoder/stack side and the call/return unit.
// The master side drives requests and the stack's top-of-stack value.
// The slave side (the unit) drives the stack strobes, the redirect and status.
interface call_ret_unit_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] stk_top;
    logic [WIDTH-1:0] stk_data;
    logic             stk_push;
    logic             stk_pop;
    logic             redir_valid;
    logic [WIDTH-1:0] redir_pc;
    logic             busy;
    logic [DW-1:0]    depth;
    logic [1:0]       err;

    modport master (
        output call, ret, pc, target, stk_top,
        input  stk_data, stk_push, stk_pop, redir_valid, redir_pc, busy, depth, err
    );

    modport slave (
        input  call, ret, pc, target, stk_top,
        output stk_data, stk_push, stk_pop, redir_valid, redir_pc, busy, depth, err
    );
endinterface

// File: rtl/call_ret_unit.sv
// Call/return sequencer: turns decoder call/ret requests into one-cycle
// push/pop strobes for an external return stack, tracks how full that stack
// is, and emits a fixed-latency fetch redirect. Overflow and underflow park
// the unit in a terminal error state until reset.
module call_ret_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic           clk,
    input  logic           reset,
    call_ret_unit_if.slave bus
);
    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        REDIR,
        ERR
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] addrLatch;
    logic [DW-1:0]    depthCount;
    logic [WIDTH-1:0] stkDataReg;
    logic             stkPushReg;
    logic             stkPopReg;
    logic             redirValidReg;
    logic [WIDTH-1:0] redirPcReg;
    logic             busyReg;
    logic [1:0]       errReg;

    // Sequencer: every output is a register updated alongside the state, so
    // nothing reaches the outputs combinationally from the request inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addrLatch     <= '0;
            depthCount    <= '0;
            stkDataReg    <= '0;
            stkPushReg    <= 1'b0;
            stkPopReg     <= 1'b0;
            redirValidReg <= 1'b0;
            redirPcReg    <= '0;
            busyReg       <= 1'b0;
            errReg        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.call) begin
                        busyReg <= 1'b1;
                        if (depthCount == FULL) begin
                            errReg <= 2'b01;
                            state  <= ERR;
                        end else begin
                            stkPushReg <= 1'b1;
                            stkDataReg <= bus.pc + WIDTH'(1);
                            addrLatch  <= bus.target;
                            state      <= PUSH;
                        end
                    end else if (bus.ret) begin
                        busyReg <= 1'b1;
                        if (depthCount == '0) begin
                            errReg <= 2'b10;
                            state  <= ERR;
                        end else begin
                            stkPopReg <= 1'b1;
                            addrLatch <= bus.stk_top;
                            state     <= POP;
                        end
                    end
                end
                PUSH: begin
                    stkPushReg    <= 1'b0;
                    depthCount    <= depthCount + DW'(1);
                    redirPcReg    <= addrLatch;
                    redirValidReg <= 1'b1;
                    state         <= REDIR;
                end
                POP: begin
                    stkPopReg     <= 1'b0;
                    depthCount    <= depthCount - DW'(1);
                    redirPcReg    <= addrLatch;
                    redirValidReg <= 1'b1;
                    state         <= REDIR;
                end
                REDIR: begin
                    redirValidReg <= 1'b0;
                    busyReg       <= 1'b0;
                    state         <= IDLE;
                end
                ERR: begin
                    stkPushReg    <= 1'b0;
                    stkPopReg     <= 1'b0;
                    redirValidReg <= 1'b0;
                    busyReg       <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stk_data    = stkDataReg;
    assign bus.stk_push    = stkPushReg;
    assign bus.stk_pop     = stkPopReg;
    assign bus.redir_valid = redirValidReg;
    assign bus.redir_pc    = redirPcReg;
    assign bus.busy        = busyReg;
    assign bus.depth       = depthCount;
    assign bus.err         = errReg;
endmodule
